// File: rtl/program_loader.sv
// program_loader
//
// Boot-time instruction loader. Receives a framed byte stream and writes
// 18-bit program words into the instruction memory write port. The
// processor is held in clear (CPU_HOLD=1) until a complete image with a
// matching checksum has been written.
//
// Frame: 0xA5, N, N x {hi, mid, lo}, checksum
//   hi[1:0] = word[17:16], hi[7:2] must be zero
//   checksum = XOR of N and every word byte (sync and checksum excluded)
//
// Ports
//   CPU_CLOCK  in   sole clock, rising edge
//   CLEAR      in   asynchronous active-low reset
//   IN_DATA    in   incoming byte
//   IN_VALID   in   IN_DATA valid
//   IN_READY   out  loader can take a byte (low only in WRITE)
//   WR_EN      out  one-cycle write strobe per word
//   WR_ADDR    out  write address (holds its last value between strobes)
//   WR_DATA    out  write data    (holds its last value between strobes)
//   CPU_HOLD   out  high keeps the processor in clear
//   DONE       out  image loaded and verified
//   ERROR      out  image rejected
//   dbg_state  out  current FSM state encoding, for checkers
//
// Handshake: a byte moves on a rising CPU_CLOCK edge where IN_VALID and
// IN_READY are both high. IN_DATA is ignored at every other edge, and the
// source may hold IN_VALID low for any number of cycles in any state.
module program_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_WIDTH = 18
) (
    input  logic                  CPU_CLOCK,
    input  logic                  CLEAR,
    input  logic [7:0]            IN_DATA,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic                  WR_EN,
    output logic [ADDR_WIDTH-1:0] WR_ADDR,
    output logic [WORD_WIDTH-1:0] WR_DATA,
    output logic                  CPU_HOLD,
    output logic                  DONE,
    output logic                  ERROR,
    output logic [3:0]            dbg_state
);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LEN   = 4'd1,
        S_HI    = 4'd2,
        S_MID   = 4'd3,
        S_LO    = 4'd4,
        S_WRITE = 4'd5,
        S_CSUM  = 4'd6,
        S_DONE  = 4'd7,
        S_ERR   = 4'd8
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [7:0]            xsum_q, xsum_d;
    logic [1:0]            hi_q, hi_d;
    logic [7:0]            mid_q, mid_d;
    logic                  wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_d;
    logic [WORD_WIDTH-1:0] wr_data_d;
    logic                  hold_d, done_d, err_d;
    logic                  accept;

    // IN_READY is the only output decoded straight from state.
    assign IN_READY  = (state_q != S_WRITE);
    assign accept    = IN_VALID && IN_READY;
    assign dbg_state = state_q;

    always_ff @(posedge CPU_CLOCK or negedge CLEAR) begin
        if (!CLEAR) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            xsum_q   <= '0;
            hi_q     <= '0;
            mid_q    <= '0;
            WR_EN    <= 1'b0;
            WR_ADDR  <= '0;
            WR_DATA  <= '0;
            CPU_HOLD <= 1'b1;
            DONE     <= 1'b0;
            ERROR    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            xsum_q   <= xsum_d;
            hi_q     <= hi_d;
            mid_q    <= mid_d;
            WR_EN    <= wr_en_d;
            WR_ADDR  <= wr_addr_d;
            WR_DATA  <= wr_data_d;
            CPU_HOLD <= hold_d;
            DONE     <= done_d;
            ERROR    <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        xsum_d    = xsum_q;
        hi_d      = hi_q;
        mid_d     = mid_q;
        wr_en_d   = 1'b0;
        wr_addr_d = WR_ADDR;
        wr_data_d = WR_DATA;
        hold_d    = CPU_HOLD;
        done_d    = DONE;
        err_d     = ERROR;

        unique case (state_q)
            // IDLE, DONE and ERR all wait for a sync byte and discard
            // everything else; a sync starts a fresh load from any of them.
            S_IDLE, S_DONE, S_ERR: begin
                if (accept && IN_DATA == SYNC_BYTE) begin
                    state_d = S_LEN;
                    idx_d   = '0;
                    xsum_d  = '0;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end

            S_LEN: begin
                if (accept) begin
                    cnt_d   = IN_DATA;
                    xsum_d  = xsum_q ^ IN_DATA;
                    state_d = (IN_DATA == 8'd0) ? S_CSUM : S_HI;
                end
            end

            S_HI: begin
                if (accept) begin
                    xsum_d = xsum_q ^ IN_DATA;
                    hi_d   = IN_DATA[1:0];
                    if (IN_DATA[7:2] != 6'd0) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_MID;
                    end
                end
            end

            S_MID: begin
                if (accept) begin
                    xsum_d  = xsum_q ^ IN_DATA;
                    mid_d   = IN_DATA;
                    state_d = S_LO;
                end
            end

            // The write strobe, address and data are registered on the
            // edge that accepts the lo byte, so they are all valid during
            // the single WRITE cycle that follows.
            S_LO: begin
                if (accept) begin
                    xsum_d    = xsum_q ^ IN_DATA;
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = {hi_q, mid_q, IN_DATA};
                    state_d   = S_WRITE;
                end
            end

            // The address wraps silently when N exceeds the memory depth.
            S_WRITE: begin
                idx_d   = idx_q + 1'b1;
                cnt_d   = cnt_q - 8'd1;
                state_d = (cnt_q == 8'd1) ? S_CSUM : S_HI;
            end

            S_CSUM: begin
                if (accept) begin
                    if (IN_DATA == xsum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    logic        CPU_CLOCK;
    logic        CLEAR;
    logic [7:0]  IN_DATA;
    logic        IN_VALID;
    logic        IN_READY;
    logic        WR_EN;
    logic [7:0]  WR_ADDR;
    logic [17:0] WR_DATA;
    logic        CPU_HOLD;
    logic        DONE;
    logic        ERROR;
    logic [3:0]  dbg_state;

    program_loader #(.ADDR_WIDTH(8), .WORD_WIDTH(18)) dut (
        .CPU_CLOCK(CPU_CLOCK),
        .CLEAR(CLEAR),
        .IN_DATA(IN_DATA),
        .IN_VALID(IN_VALID),
        .IN_READY(IN_READY),
        .WR_EN(WR_EN),
        .WR_ADDR(WR_ADDR),
        .WR_DATA(WR_DATA),
        .CPU_HOLD(CPU_HOLD),
        .DONE(DONE),
        .ERROR(ERROR),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CPU_CLOCK = 1'b0;
        forever #5 CPU_CLOCK = ~CPU_CLOCK;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;

    logic [25:0] exp_q[$];   // {addr, data} expected writes
    logic [25:0] obs_q[$];   // {addr, data} observed writes
    logic [7:0]  stim_q[$];
    int          exp_words;
    int          ready_low;
    logic        m_hold, m_done, m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    always @(negedge CPU_CLOCK) begin
        if (CLEAR) begin
            if (WR_EN) obs_q.push_back({WR_ADDR, WR_DATA});
            if (!IN_READY) ready_low++;
        end
    end

    // ---------------- reference model ----------------
    // Interprets a complete byte stream frame by frame.
    task automatic model_feed();
        int p;
        int n;
        logic [7:0] x, b0, b1, b2;
        bit aborted;
        p = 0;
        while (p < stim_q.size()) begin
            if (stim_q[p] != 8'hA5) begin
                p++;
                continue;
            end
            p++;
            m_hold = 1'b1; m_done = 1'b0; m_err = 1'b0;
            n = stim_q[p];
            x = stim_q[p];
            p++;
            aborted = 1'b0;
            for (int w = 0; w < n && !aborted; w++) begin
                b0 = stim_q[p];
                p++;
                if (b0[7:2] != 6'd0) begin
                    m_err   = 1'b1;
                    aborted = 1'b1;
                end else begin
                    b1 = stim_q[p];
                    b2 = stim_q[p+1];
                    p += 2;
                    x = x ^ b0 ^ b1 ^ b2;
                    exp_q.push_back({w[7:0], b0[1:0], b1, b2});
                    exp_words++;
                end
            end
            if (!aborted) begin
                if (stim_q[p] == x) begin
                    m_done = 1'b1;
                    m_hold = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
                p++;
            end
        end
    endtask

    task automatic model_reset();
        m_hold = 1'b1; m_done = 1'b0; m_err = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        IN_VALID = 1'b0;
        repeat (n) begin
            IN_DATA = 8'($urandom);
            @(posedge CPU_CLOCK);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        int guard;
        IN_VALID = 1'b1;
        IN_DATA  = b;
        guard    = 0;
        rdy      = 1'b0;
        while (!rdy && guard < 16) begin
            @(negedge CPU_CLOCK);
            rdy = IN_READY;
            @(posedge CPU_CLOCK);
            #1;
            guard++;
        end
        if (!rdy) check("send_timeout", 32'd0, 32'd1);
        IN_VALID = 1'b0;
        IN_DATA  = 8'($urandom);
    endtask

    task automatic start_scn();
        exp_q.delete();
        obs_q.delete();
        stim_q.delete();
        exp_words = 0;
        ready_low = 0;
    endtask

    task automatic run_stream(input int max_stall);
        model_feed();
        foreach (stim_q[i]) begin
            if (max_stall > 0) idle($urandom_range(1, max_stall));
            send_byte(stim_q[i]);
        end
    endtask

    task automatic check_result(input string tag);
        idle(4);
        check({tag, "_nwr"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check({tag, "_wr"}, obs_q.pop_front(), exp_q.pop_front());
        check({tag, "_rdylow"}, ready_low, exp_words);
        check({tag, "_done"}, DONE, m_done);
        check({tag, "_err"}, ERROR, m_err);
        check({tag, "_hold"}, CPU_HOLD, m_hold);
    endtask

    task automatic push_good();
        stim_q.push_back(8'hA5); stim_q.push_back(8'h02);
        stim_q.push_back(8'h00); stim_q.push_back(8'hC1); stim_q.push_back(8'h5F);
        stim_q.push_back(8'h02); stim_q.push_back(8'h44); stim_q.push_back(8'h34);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"}, IN_READY, 1'b1);
        check({tag, "_wren"}, WR_EN, 1'b0);
        check({tag, "_addr"}, WR_ADDR, 8'h00);
        check({tag, "_data"}, WR_DATA, 18'h0);
        check({tag, "_hold"}, CPU_HOLD, 1'b1);
        check({tag, "_done"}, DONE, 1'b0);
        check({tag, "_err"}, ERROR, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] b, x, cs;
        int n, bad_at;

        CLEAR    = 1'b0;
        IN_VALID = 1'b0;
        IN_DATA  = 8'hA5;
        model_reset();

        // Reset with input toggling
        repeat (4) begin
            @(posedge CPU_CLOCK);
            #1;
            IN_VALID = ~IN_VALID;
            IN_DATA  = 8'hA5;
        end
        check_reset_vals("rst");
        IN_VALID = 1'b0;
        CLEAR    = 1'b1;
        idle(3);
        check_reset_vals("rst_rel");

        // Good load, back-to-back, with latency checks
        start_scn();
        push_good();
        stim_q.push_back(8'hEE);
        model_feed();
        foreach (stim_q[i]) begin
            send_byte(stim_q[i]);
            if (i == 4) begin
                check("good_wr0_en", WR_EN, 1'b1);
                check("good_wr0", {WR_ADDR, WR_DATA}, {8'd0, 18'h0C15F});
                check("good_wr0_rdy", IN_READY, 1'b0);
            end
            if (i == 7) check("good_wr1", {WR_EN, WR_ADDR, WR_DATA}, {1'b1, 8'd1, 18'h24434});
            if (i == 8) check("good_done_lat", {DONE, CPU_HOLD}, 2'b10);
        end
        check_result("good");

        // Bad checksum, then empty image
        start_scn();
        push_good();
        stim_q.push_back(8'hEF);
        run_stream(0);
        check("badcs_err_const", {ERROR, DONE, CPU_HOLD}, 3'b101);
        check_result("badcs");
        start_scn();
        stim_q = '{8'hA5, 8'h00, 8'h00};
        run_stream(0);
        check("empty_const", {ERROR, DONE, CPU_HOLD}, 3'b010);
        check_result("empty");

        // Junk before sync
        start_scn();
        stim_q = '{8'h13, 8'h37, 8'hA5, 8'h00, 8'h00};
        run_stream(0);
        check_result("junk");

        // Bad hi byte
        start_scn();
        stim_q = '{8'hA5, 8'h01, 8'h04};
        model_feed();
        foreach (stim_q[i]) send_byte(stim_q[i]);
        check("badhi_lat", {ERROR, DONE, CPU_HOLD}, 3'b101);
        send_byte(8'h00);
        send_byte(8'h00);
        check_result("badhi");

        // Stalled good load
        start_scn();
        push_good();
        stim_q.push_back(8'hEE);
        run_stream(3);
        check_result("stall");

        // Reset mid-load, then reload
        start_scn();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'hC1); send_byte(8'h5F);
        CLEAR = 1'b0;
        #1;
        check_reset_vals("midrst");
        idle(2);
        CLEAR = 1'b1;
        model_reset();
        idle(3);
        check("midrst_nowr", obs_q.size(), 0);
        start_scn();
        push_good();
        stim_q.push_back(8'hEE);
        run_stream(2);
        check_result("reload");

        // Random frames
        for (int f = 0; f < 30; f++) begin
            start_scn();
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                stim_q.push_back(b);
            end
            n = $urandom_range(0, 6);
            stim_q.push_back(8'hA5);
            stim_q.push_back(8'(n));
            x = 8'(n);
            bad_at = (n > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
            for (int w = 0; w < n; w++) begin
                if (w == bad_at) begin
                    stim_q.push_back({6'($urandom_range(1, 63)), 2'($urandom)});
                    break;
                end
                b = {6'd0, 2'($urandom)};
                stim_q.push_back(b); x ^= b;
                b = 8'($urandom);
                stim_q.push_back(b); x ^= b;
                b = 8'($urandom);
                stim_q.push_back(b); x ^= b;
            end
            if (bad_at < 0) begin
                cs = x;
                if ($urandom_range(0, 3) == 0) cs ^= 8'(1 << $urandom_range(0, 7));
                stim_q.push_back(cs);
            end
            run_stream($urandom_range(0, 3));
            check_result("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
